mac_arbiter: RTL and testbench
==============================

# mac_arbiter

Two-requester front end for the square-accumulate datapath. Requesters share one multiply-accumulate path through a round-robin arbiter with a valid/ready handshake. Each requester has its own accumulator bank, valid pulse and sticky overflow flag. The block sits between the input producers and downstream consumers; it replaces per-channel duplicated MAC instances.

## Interface
Parameters:
- IN_W, default 8: operand width.
- ACC_W, default 20: accumulator width.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low; asserted when 0 at a rising edge of clk.
- a0  input  IN_W  operand, requester 0.
- valid_in0  input  1  requester 0 offers a0/clr0.
- clr0  input  1  qualifies the transfer; accumulator 0 restarts from this operand.
- ready0  output  1  grant to requester 0; a transfer occurs when valid_in0 && ready0.
- a1, valid_in1, clr1, ready1: same as above, for requester 1.
- f0  output  ACC_W  accumulator 0.
- valid_out0  output  1  one-cycle pulse; f0 was just updated.
- overflow0  output  1  sticky; accumulator 0 wrapped.
- f1, valid_out1, overflow1: same as above, for requester 1.

## Operation
- Arbiter state is a last-grant pointer with two states, LAST0 and LAST1. Reset value is LAST1, so requester 0 wins the first tie.
- Combinational grant:
  - Only valid_in0 high: ready0=1.
  - Only valid_in1 high: ready1=1.
  - Both high: grant the requester not named by the pointer.
  - Neither high: both ready low.
  - ready0 and ready1 are never high together.
  - Both ready outputs are 0 while reset is asserted.
- Pointer update: on a transfer, the pointer moves to the granted id. With no transfer it holds.
- Stage S1 is registered at the transfer edge. It captures:
  - the selected operand;
  - the id;
  - the clr bit;
  - s1_valid=1.
  - With no transfer, s1_valid=0 and the other S1 fields hold.
- Stage S2 runs when s1_valid=1:
  - sq = operand*operand, 2*IN_W bits, zero-extended to ACC_W+1 bits.
  - base = 0 if clr, otherwise f_id.
  - sum = base + sq, ACC_W+1 bits.
  - f_id <= sum[ACC_W-1:0], so the accumulator wraps modulo 2^ACC_W.
  - valid_out_id <= 1.
  - If clr=1: overflow_id <= sum[ACC_W].
  - If clr=0: overflow_id <= overflow_id | sum[ACC_W].
- The accumulator and flags of the requester not named by id are untouched.
- valid_out0 and valid_out1 are 0 on every cycle with no S2 update for that id. Both are never high together.
- Reset:
  - f0, f1, overflow0/1 and valid_out0/1 are all 0.
  - The pointer goes to LAST1.
  - s1_valid goes to 0. Any operand in flight is discarded and produces no valid_out.

## Timing
- Throughput: at most one transfer per cycle across both requesters.
- Latency: for a transfer at edge k, f_id and valid_out_id update at edge k+1. They are visible after edge k+1 and valid_out_id falls at edge k+2 unless another same-id update occurs.
- Back-to-back same-id transfers accumulate correctly, with no bubble. S2 reads the f_id written at the previous edge.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1,... Neither requester waits more than one cycle.
- A requester must hold a, valid_in and clr stable until it sees ready high. Deasserting valid_in without a transfer is permitted.
- Simultaneous clr and transfer: clr acts only on a transfer. clr with no transfer is ignored.
- Reset sampled at edge k+1 while S1 holds a transfer from edge k:
  - the transfer is dropped;
  - after the edge, f_id=0 and valid_out_id=0.

## Test plan
1. Reset: hold reset=0 for 2 cycles with valid_in0=valid_in1=1.
   - Required: ready0=ready1=0 during reset; f0=f1=0, valid_out0/1=0, overflow0/1=0.
2. Single requester: requester 0 sends a0=21 and then a0=36 on consecutive cycles, with clr0=0.
   - Required: valid_out0 is high for 2 cycles; f0=441 and then 1737.
   - Required: f1=0 and valid_out1=0 throughout.
3. Contention: both requesters valid for 4 cycles with a0=2 and a1=3.
   - Required: grants go 0,1,0,1.
   - Required: f0 reads 4 and then 8; f1 reads 9 and then 18; the valid_out pulses alternate.
4. Clear: requester 0 has accumulated f0=1737; then accept a0=5 with clr0=1.
   - Required: f0=25 and overflow0=0 one cycle later.
5. Overflow: requester 1 sends 17 transfers of a1=255.
   - Required after the 16th: f1=1040400 and overflow1=0.
   - Required after the 17th: f1=56849 and overflow1=1.
   - Then a1=1 with clr1=1: required f1=1 and overflow1=0.
6. Reset mid-operation: accept a0=10 at edge k and assert reset=0 at edge k+1.
   - Required: no valid_out0 pulse and f0=0.
   - After release, the first tie is granted to requester 0.

Source files
------------

// File: rtl/mac_arbiter.sv
// Two-requester round-robin front end sharing one square-accumulate path.
// Each requester owns its accumulator, valid_out pulse and sticky overflow flag.
module mac_arbiter #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a0,
    input  logic             valid_in0,
    input  logic             clr0,
    output logic             ready0,
    input  logic [IN_W-1:0]  a1,
    input  logic             valid_in1,
    input  logic             clr1,
    output logic             ready1,
    output logic [ACC_W-1:0] f0,
    output logic             valid_out0,
    output logic             overflow0,
    output logic [ACC_W-1:0] f1,
    output logic             valid_out1,
    output logic             overflow1
);

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } ptr_e;

    ptr_e             ptr_q, ptr_d;
    logic             xfer;

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_a_q, s1_a_d;
    logic             s1_id_q, s1_id_d;
    logic             s1_clr_q, s1_clr_d;

    logic [ACC_W-1:0] f0_q, f0_d, f1_q, f1_d;
    logic             valid_out0_q, valid_out0_d, valid_out1_q, valid_out1_d;
    logic             overflow0_q, overflow0_d, overflow1_q, overflow1_d;

    logic [ACC_W:0]   sq, base, sum;

    // Grant: the requester not named by the last-grant pointer wins a tie.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (reset) begin
            if (valid_in0 && valid_in1) begin
                if (ptr_q == LAST1) ready0 = 1'b1;
                else                ready1 = 1'b1;
            end else if (valid_in0) begin
                ready0 = 1'b1;
            end else if (valid_in1) begin
                ready1 = 1'b1;
            end
        end
    end

    always_comb begin
        xfer     = (valid_in0 && ready0) || (valid_in1 && ready1);
        ptr_d    = ptr_q;
        s1_valid_d = xfer;
        s1_a_d   = s1_a_q;
        s1_id_d  = s1_id_q;
        s1_clr_d = s1_clr_q;
        if (xfer) begin
            ptr_d    = ready1 ? LAST1 : LAST0;
            s1_a_d   = ready1 ? a1 : a0;
            s1_id_d  = ready1;
            s1_clr_d = ready1 ? clr1 : clr0;
        end
    end

    // Operands are widened before multiplying; ACC_W+1 must hold the 2*IN_W-bit square.
    always_comb begin
        sq   = (ACC_W+1)'(s1_a_q) * (ACC_W+1)'(s1_a_q);
        base = s1_clr_q ? '0 : {1'b0, (s1_id_q ? f1_q : f0_q)};
        sum  = base + sq;

        f0_d         = f0_q;
        f1_d         = f1_q;
        overflow0_d  = overflow0_q;
        overflow1_d  = overflow1_q;
        valid_out0_d = 1'b0;
        valid_out1_d = 1'b0;

        if (s1_valid_q) begin
            if (!s1_id_q) begin
                f0_d         = sum[ACC_W-1:0];
                valid_out0_d = 1'b1;
                overflow0_d  = s1_clr_q ? sum[ACC_W] : (overflow0_q | sum[ACC_W]);
            end else begin
                f1_d         = sum[ACC_W-1:0];
                valid_out1_d = 1'b1;
                overflow1_d  = s1_clr_q ? sum[ACC_W] : (overflow1_q | sum[ACC_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q        <= LAST1;
            s1_valid_q   <= 1'b0;
            f0_q         <= '0;
            f1_q         <= '0;
            valid_out0_q <= 1'b0;
            valid_out1_q <= 1'b0;
            overflow0_q  <= 1'b0;
            overflow1_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            f0_q         <= f0_d;
            f1_q         <= f1_d;
            valid_out0_q <= valid_out0_d;
            valid_out1_q <= valid_out1_d;
            overflow0_q  <= overflow0_d;
            overflow1_q  <= overflow1_d;
        end
    end

    // NOTE: the S1 payload is only meaningful when s1_valid_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_a_q   <= s1_a_d;
        s1_id_q  <= s1_id_d;
        s1_clr_q <= s1_clr_d;
    end

    assign f0         = f0_q;
    assign f1         = f1_q;
    assign valid_out0 = valid_out0_q;
    assign valid_out1 = valid_out1_q;
    assign overflow0  = overflow0_q;
    assign overflow1  = overflow1_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: a vector table for reset/contention, hand-written
// sequences for accumulate, clear, overflow and mid-flight reset, and a scoreboard.
module tb_mac_arbiter;

    localparam int IN_W  = 8;
    localparam int ACC_W = 20;
    localparam longint MOD = 64'd1 << ACC_W;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  a0, a1;
    logic             valid_in0, valid_in1, clr0, clr1;
    logic             ready0, ready1;
    logic [ACC_W-1:0] f0, f1;
    logic             valid_out0, valid_out1, overflow0, overflow1;

    mac_arbiter #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a0         (a0),
        .valid_in0  (valid_in0),
        .clr0       (clr0),
        .ready0     (ready0),
        .a1         (a1),
        .valid_in1  (valid_in1),
        .clr1       (clr1),
        .ready1     (ready1),
        .f0         (f0),
        .valid_out0 (valid_out0),
        .overflow0  (overflow0),
        .f1         (f1),
        .valid_out1 (valid_out1),
        .overflow1  (overflow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            v0;
        logic [IN_W-1:0] a0;
        logic            c0;
        logic            v1;
        logic [IN_W-1:0] a1;
        logic            c1;
        logic            r0;
        logic            r1;
        int              ef0;
        int              ef1;
    } vec_t;

    typedef struct {
        logic            id;
        logic [IN_W-1:0] a;
        logic            clr;
    } xfer_t;

    xfer_t  sb[$];
    longint m_f [2];
    logic   m_o [2];
    int     n_vec;
    int     n_err;
    vec_t   tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, check grant, then check the update of the previous transfer.
    task automatic step(input logic s_rst, input logic s_v0, input logic [IN_W-1:0] s_a0,
                        input logic s_c0, input logic s_v1, input logic [IN_W-1:0] s_a1,
                        input logic s_c1, input logic e_r0, input logic e_r1);
        xfer_t  e;
        longint s;
        logic   ov;
        @(negedge clk);
        reset = s_rst; valid_in0 = s_v0; a0 = s_a0; clr0 = s_c0;
        valid_in1 = s_v1; a1 = s_a1; clr1 = s_c1;
        #1;
        check("ready0", 32'(ready0), 32'(e_r0));
        check("ready1", 32'(ready1), 32'(e_r1));
        @(posedge clk);
        #1;
        if (!s_rst) begin
            sb.delete();
            m_f[0] = 0; m_f[1] = 0; m_o[0] = 1'b0; m_o[1] = 1'b0;
            check("rst_valid_out0", 32'(valid_out0), 32'd0);
            check("rst_valid_out1", 32'(valid_out1), 32'd0);
            check("rst_f0", 32'(f0), 32'd0);
            check("rst_f1", 32'(f1), 32'd0);
            check("rst_overflow0", 32'(overflow0), 32'd0);
            check("rst_overflow1", 32'(overflow1), 32'd0);
        end else if (sb.size() > 0) begin
            e  = sb.pop_front();
            s  = (e.clr ? 64'd0 : m_f[e.id]) + longint'(e.a) * longint'(e.a);
            ov = (s >= MOD);
            m_f[e.id] = s % MOD;
            m_o[e.id] = e.clr ? ov : (m_o[e.id] | ov);
            check("sb_valid_out0", 32'(valid_out0), 32'(e.id == 1'b0));
            check("sb_valid_out1", 32'(valid_out1), 32'(e.id == 1'b1));
            check("sb_f0", 32'(f0), 32'(m_f[0]));
            check("sb_f1", 32'(f1), 32'(m_f[1]));
            check("sb_overflow0", 32'(overflow0), 32'(m_o[0]));
            check("sb_overflow1", 32'(overflow1), 32'(m_o[1]));
        end else begin
            check("idle_valid_out0", 32'(valid_out0), 32'd0);
            check("idle_valid_out1", 32'(valid_out1), 32'd0);
        end
        if ((s_v0 && e_r0) || (s_v1 && e_r1))
            sb.push_back('{id: e_r1, a: (e_r1 ? s_a1 : s_a0), clr: (e_r1 ? s_c1 : s_c0)});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_f[0] = 0; m_f[1] = 0; m_o[0] = 1'b0; m_o[1] = 1'b0;
        reset = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
        a0 = '0; a1 = '0; clr0 = 1'b0; clr1 = 1'b0;

        // Reset with both valid, then contention with a0=2, a1=3.
        tbl[0] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[3] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 4, 0};
        tbl[4] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 4, 9};
        tbl[5] = '{1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8, 9};
        tbl[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8, 18};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rst, tbl[i].v0, tbl[i].a0, tbl[i].c0,
                 tbl[i].v1, tbl[i].a1, tbl[i].c1, tbl[i].r0, tbl[i].r1);
            check($sformatf("tbl%0d_f0", i), 32'(f0), 32'(tbl[i].ef0));
            check($sformatf("tbl%0d_f1", i), 32'(f1), 32'(tbl[i].ef1));
        end

        // Single requester accumulate: 21 then 36.
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd21, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd36, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("single_f0_441", 32'(f0), 32'd441);
        check("single_vo0_first", 32'(valid_out0), 32'd1);
        idle();
        check("single_f0_1737", 32'(f0), 32'd1737);
        check("single_vo0_second", 32'(valid_out0), 32'd1);
        check("single_f1", 32'(f1), 32'd0);

        // Clear restarts the accumulator from the new operand.
        step(1'b1, 1'b1, 8'd5, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        idle();
        check("clear_f0", 32'(f0), 32'd25);
        check("clear_overflow0", 32'(overflow0), 32'd0);

        // Overflow: 17 squares of 255 on requester 1, then a clearing transfer.
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b1);
        check("ovf_f1_16", 32'(f1), 32'd1040400);
        check("ovf_flag_16", 32'(overflow1), 32'd0);
        idle();
        check("ovf_f1_17", 32'(f1), 32'd56849);
        check("ovf_flag_17", 32'(overflow1), 32'd1);
        check("ovf_f0_untouched", 32'(f0), 32'd25);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        idle();
        check("ovf_clr_f1", 32'(f1), 32'd1);
        check("ovf_clr_flag", 32'(overflow1), 32'd0);

        // Reset while a transfer is in S1: it must vanish; the next tie goes to requester 0.
        step(1'b1, 1'b1, 8'd10, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("midrst_f0", 32'(f0), 32'd0);
        check("midrst_vo0", 32'(valid_out0), 32'd0);
        idle();
        check("midrst_no_late_pulse", 32'(valid_out0), 32'd0);
        step(1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 8'd6, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd4, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1);
        check("post_rst_f0", 32'(f0), 32'd16);
        idle();
        check("post_rst_f1", 32'(f1), 32'd36);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
